// File: rtl/ysyx_23060208_mem_arbiter.sv
// Round-robin arbiter giving the IFU and LSU turns on one valid/ready memory port.
// Only one transaction is in flight; its response returns to the requester that issued it.
module ysyx_23060208_mem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [DATA_WIDTH-1:0]     ifu_addr,
    output logic                      ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,
    input  logic                      ifu_resp_ready,

    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [DATA_WIDTH-1:0]     lsu_addr,
    input  logic                      lsu_wen,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
    output logic                      lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,
    input  logic                      lsu_resp_ready,

    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic                      mem_wen,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_resp_ready
);

    localparam int   MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic SEL_IFU    = 1'b0;
    localparam logic SEL_LSU    = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic                    last_reg, last_next;
    logic                    owner_reg, owner_next;
    logic [DATA_WIDTH-1:0]   addr_reg, addr_next;
    logic                    wen_reg, wen_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [MASK_WIDTH-1:0]   wmask_reg, wmask_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;

    logic                    grant_ifu, grant_lsu;
    logic                    owner_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= SEL_IFU;
            owner_reg <= SEL_IFU;
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            wmask_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            addr_reg  <= addr_next;
            wen_reg   <= wen_next;
            wdata_reg <= wdata_next;
            wmask_reg <= wmask_next;
            data_reg  <= data_next;
        end
    end

    // On a tie the LSU wins unless it was the previous grantee.
    assign grant_lsu        = lsu_req_valid && (!ifu_req_valid || (last_reg == SEL_IFU));
    assign grant_ifu        = ifu_req_valid && !grant_lsu;
    assign owner_resp_ready = (owner_reg == SEL_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        owner_next    = owner_reg;
        addr_next     = addr_reg;
        wen_next      = wen_reg;
        wdata_next    = wdata_reg;
        wmask_next    = wmask_reg;
        data_next     = data_reg;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;

        case (state_reg)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_lsu) begin
                    addr_next  = lsu_addr;
                    wen_next   = lsu_wen;
                    wdata_next = lsu_wdata;
                    wmask_next = lsu_wmask;
                    owner_next = SEL_LSU;
                    last_next  = SEL_LSU;
                    state_next = REQ;
                end else if (grant_ifu) begin
                    // Fetches are always reads with no byte lanes enabled.
                    addr_next  = ifu_addr;
                    wen_next   = 1'b0;
                    wdata_next = '0;
                    wmask_next = '0;
                    owner_next = SEL_IFU;
                    last_next  = SEL_IFU;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    data_next  = mem_rdata;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory-side and response valids come only from registered state.
    assign mem_req_valid  = (state_reg == REQ);
    assign mem_resp_ready = (state_reg == WAIT);
    assign mem_addr       = addr_reg;
    assign mem_wen        = wen_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_wmask      = wmask_reg;

    assign ifu_resp_valid = (state_reg == RESP) && (owner_reg == SEL_IFU);
    assign lsu_resp_valid = (state_reg == RESP) && (owner_reg == SEL_LSU);
    assign ifu_rdata      = data_reg;
    assign lsu_rdata      = data_reg;

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_ysyx_23060208_mem_arbiter;

    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [DW-1:0] ifu_addr, ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [DW-1:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060208_mem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_ready (ifu_resp_ready),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_ready (lsu_resp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .mem_resp_ready (mem_resp_ready)
    );

    typedef struct {
        logic          iv;
        logic          lv;
        logic          exp_lsu;
        logic [DW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".ifu_req_ready"}, ifu_req_ready, 1'b0);
        chk1({tag, ".lsu_req_ready"}, lsu_req_ready, 1'b0);
        chk1({tag, ".ifu_resp_valid"}, ifu_resp_valid, 1'b0);
        chk1({tag, ".lsu_resp_valid"}, lsu_resp_valid, 1'b0);
        chk1({tag, ".mem_req_valid"}, mem_req_valid, 1'b0);
        chk1({tag, ".mem_resp_ready"}, mem_resp_ready, 1'b0);
        chk1({tag, ".mem_wen"}, mem_wen, 1'b0);
        chk32({tag, ".mem_addr"}, mem_addr, 32'h0);
        chk32({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, ".mem_wmask"}, 32'(mem_wmask), 32'h0);
        chk32({tag, ".ifu_rdata"}, ifu_rdata, 32'h0);
        chk32({tag, ".lsu_rdata"}, lsu_rdata, 32'h0);
    endtask

    function automatic vec_t mk(input logic iv, input logic lv, input logic exp_lsu,
                                input logic [DW-1:0] addr, input logic wen,
                                input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                                input logic [DW-1:0] rdata);
        vec_t v;
        v.iv = iv; v.lv = lv; v.exp_lsu = exp_lsu; v.addr = addr;
        v.wen = wen; v.wdata = wdata; v.wmask = wmask; v.rdata = rdata;
        return v;
    endfunction

    // Zero-wait transaction; the LSU address is the row address plus 4 so the
    // granted side is visible on mem_addr. Valids stay up for the whole transaction.
    task automatic run_vec(input vec_t v, input int idx);
        logic [DW-1:0] exp_addr;
        exp_addr       = v.exp_lsu ? v.addr + 32'd4 : v.addr;
        ifu_req_valid  = v.iv;
        lsu_req_valid  = v.lv;
        ifu_addr       = v.addr;
        lsu_addr       = v.addr + 32'd4;
        lsu_wen        = v.wen;
        lsu_wdata      = v.wdata;
        lsu_wmask      = v.wmask;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = v.rdata;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        chk1($sformatf("v%0d.T.ifu_req_ready", idx), ifu_req_ready, v.iv & ~v.exp_lsu);
        chk1($sformatf("v%0d.T.lsu_req_ready", idx), lsu_req_ready, v.exp_lsu);
        tick();
        @(negedge clk);
        chk1($sformatf("v%0d.T1.mem_req_valid", idx), mem_req_valid, 1'b1);
        chk32($sformatf("v%0d.T1.mem_addr", idx), mem_addr, exp_addr);
        chk1($sformatf("v%0d.T1.mem_wen", idx), mem_wen, v.exp_lsu & v.wen);
        chk32($sformatf("v%0d.T1.mem_wmask", idx), 32'(mem_wmask), v.exp_lsu ? 32'(v.wmask) : 32'h0);
        if (v.exp_lsu) chk32($sformatf("v%0d.T1.mem_wdata", idx), mem_wdata, v.wdata);
        chk1($sformatf("v%0d.T1.req_ready", idx), ifu_req_ready | lsu_req_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1($sformatf("v%0d.T2.mem_resp_ready", idx), mem_resp_ready, 1'b1);
        chk1($sformatf("v%0d.T2.mem_req_valid", idx), mem_req_valid, 1'b0);
        tick();
        @(negedge clk);
        chk1($sformatf("v%0d.T3.ifu_resp_valid", idx), ifu_resp_valid, ~v.exp_lsu);
        chk1($sformatf("v%0d.T3.lsu_resp_valid", idx), lsu_resp_valid, v.exp_lsu);
        chk32($sformatf("v%0d.T3.ifu_rdata", idx), ifu_rdata, v.rdata);
        chk32($sformatf("v%0d.T3.lsu_rdata", idx), lsu_rdata, v.rdata);
        chk1($sformatf("v%0d.T3.req_ready", idx), ifu_req_ready | lsu_req_ready, 1'b0);
        $display("vec %0d: grant=%s addr=%h rdata=%h", idx, v.exp_lsu ? "LSU" : "IFU", exp_addr, v.rdata);
        tick();
    endtask

    function automatic logic [DW-1:0] rand_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
    endfunction

    // Randomized-phase state: the bench's memory and the reference model.
    logic [DW-1:0] mem_arr [64];
    logic [DW-1:0] ref_mem [64];
    logic          mem_has;
    int            mem_delay;
    logic [DW-1:0] mem_hold;
    logic          m_busy, m_req_pending, m_wait, m_resp_pending, m_owner, m_last;
    logic [DW-1:0] e_addr, e_wdata, e_rd, m_data;
    logic          e_wen;
    logic [MW-1:0] e_wmask;
    logic          e_ifu_rdy, e_lsu_rdy, ifu_took, lsu_took;
    int            ntx;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nresp;

        set_idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        tick();

        vecs[0] = mk(1, 1, 1, 32'h8000_0100, 0, 32'h0,         4'h0, 32'h1111_1111);
        vecs[1] = mk(1, 1, 0, 32'h8000_0200, 1, 32'h0BAD_0BAD, 4'hF, 32'h2222_2222);
        vecs[2] = mk(1, 1, 1, 32'h8000_0300, 1, 32'hAABB_CCDD, 4'hF, 32'h3333_3333);
        vecs[3] = mk(1, 0, 0, 32'h8000_0000, 0, 32'h0,         4'h0, 32'h0000_0413);
        vecs[4] = mk(0, 1, 1, 32'h8000_0400, 1, 32'h0102_0304, 4'h5, 32'h4444_4444);
        vecs[5] = mk(0, 1, 1, 32'h8000_0500, 0, 32'h0,         4'h0, 32'h5555_5555);
        vecs[6] = mk(1, 1, 0, 32'h8000_0600, 1, 32'hFFFF_FFFF, 4'hF, 32'h6666_6666);
        vecs[7] = mk(1, 0, 0, 32'h8000_0700, 0, 32'h0,         4'h0, 32'h7777_7777);
        vecs[8] = mk(1, 1, 1, 32'h8000_0800, 0, 32'h0,         4'h0, 32'h8888_8888);
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // LSU write stalled by mem_req_ready, then a 5-cycle response delay.
        set_idle_inputs();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'b0011;
        @(negedge clk);
        chk1("wr.lsu_req_ready", lsu_req_ready, 1'b1);
        tick();
        set_idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("wr.stall%0d.mem_req_valid", i), mem_req_valid, 1'b1);
            chk32($sformatf("wr.stall%0d.mem_addr", i), mem_addr, 32'h8000_1000);
            chk1($sformatf("wr.stall%0d.mem_wen", i), mem_wen, 1'b1);
            chk32($sformatf("wr.stall%0d.mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
            chk32($sformatf("wr.stall%0d.mem_wmask", i), 32'(mem_wmask), 32'h3);
            tick();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("wr.accept.mem_req_valid", mem_req_valid, 1'b1);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1($sformatf("wr.wait%0d.mem_resp_ready", i), mem_resp_ready, 1'b1);
            chk1($sformatf("wr.wait%0d.lsu_resp_valid", i), lsu_resp_valid, 1'b0);
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        lsu_resp_ready = 1'b1;
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lsu_resp_valid) begin
                nresp++;
                chk32("wr.lsu_rdata", lsu_rdata, 32'h1234_5678);
            end
            tick();
        end
        chk32("wr.resp_count", 32'(nresp), 32'd1);
        $display("seq write-stall: responses=%0d", nresp);

        // IFU response backpressure with a second fetch already pending.
        set_idle_inputs();
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0004;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("bp.ifu_req_ready", ifu_req_ready, 1'b1);
        tick();
        tick();
        tick();
        mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1($sformatf("bp%0d.ifu_resp_valid", i), ifu_resp_valid, 1'b1);
            chk32($sformatf("bp%0d.ifu_rdata", i), ifu_rdata, 32'hCAFE_F00D);
            chk1($sformatf("bp%0d.ifu_req_ready", i), ifu_req_ready, 1'b0);
            tick();
        end
        ifu_resp_ready = 1'b1;
        @(negedge clk);
        chk1("bp.hs.ifu_resp_valid", ifu_resp_valid, 1'b1);
        chk1("bp.hs.ifu_req_ready", ifu_req_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1("bp.next.ifu_req_ready", ifu_req_ready, 1'b1);
        chk1("bp.next.ifu_resp_valid", ifu_resp_valid, 1'b0);
        ifu_req_valid = 1'b0;
        tick();
        $display("seq ifu-backpressure: done");

        // Reset while waiting for memory; last must return to IFU.
        set_idle_inputs();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk1("rst.tie.lsu_req_ready", lsu_req_ready, 1'b1);
        tick();
        set_idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        @(negedge clk);
        chk1("rst.wait.mem_resp_ready", mem_resp_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_idle_inputs();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5A5A_5A5A;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        tick();
        @(negedge clk);
        chk1("midrst.later.lsu_resp_valid", lsu_resp_valid, 1'b0);
        tick();
        run_vec(mk(1, 1, 1, 32'h8000_3000, 0, 32'h0, 4'h0, 32'h9999_9999), 9);

        // Randomized traffic against the transaction-level model.
        set_idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = mem_arr[i];
        end
        mem_has = 1'b0; mem_delay = 0; mem_hold = '0;
        m_busy = 1'b0; m_req_pending = 1'b0; m_wait = 1'b0; m_resp_pending = 1'b0;
        m_owner = 1'b0; m_last = 1'b0; m_data = '0; e_rd = '0;
        e_addr = '0; e_wdata = '0; e_wen = 1'b0; e_wmask = '0;
        ifu_took = 1'b0; lsu_took = 1'b0; ntx = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!ifu_req_valid || ifu_took) begin
                ifu_req_valid = ($urandom_range(0, 2) == 0);
                ifu_addr      = rand_addr();
            end
            if (!lsu_req_valid || lsu_took) begin
                lsu_req_valid = ($urandom_range(0, 2) == 0);
                lsu_addr      = rand_addr();
                lsu_wen       = 1'($urandom_range(0, 1));
                lsu_wdata     = $urandom;
                lsu_wmask     = 4'($urandom_range(0, 15));
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            if (mem_has && mem_delay > 0) mem_delay--;
            mem_resp_valid = mem_has && (mem_delay == 0);
            mem_rdata      = mem_resp_valid ? mem_hold : $urandom;
            ifu_resp_ready = 1'($urandom_range(0, 1));
            lsu_resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);

            e_ifu_rdy = 1'b0;
            e_lsu_rdy = 1'b0;
            if (!m_busy) begin
                if (lsu_req_valid && (!ifu_req_valid || !m_last)) e_lsu_rdy = 1'b1;
                else if (ifu_req_valid) e_ifu_rdy = 1'b1;
            end
            chk1($sformatf("r%0d.ifu_req_ready", cyc), ifu_req_ready, e_ifu_rdy);
            chk1($sformatf("r%0d.lsu_req_ready", cyc), lsu_req_ready, e_lsu_rdy);
            chk1($sformatf("r%0d.mem_req_valid", cyc), mem_req_valid, m_req_pending);
            chk1($sformatf("r%0d.mem_resp_ready", cyc), mem_resp_ready, m_wait);
            chk1($sformatf("r%0d.ifu_resp_valid", cyc), ifu_resp_valid, m_resp_pending & ~m_owner);
            chk1($sformatf("r%0d.lsu_resp_valid", cyc), lsu_resp_valid, m_resp_pending & m_owner);
            if (m_req_pending) begin
                chk32($sformatf("r%0d.mem_addr", cyc), mem_addr, e_addr);
                chk1($sformatf("r%0d.mem_wen", cyc), mem_wen, e_wen);
                chk32($sformatf("r%0d.mem_wmask", cyc), 32'(mem_wmask), 32'(e_wmask));
                if (e_wen) chk32($sformatf("r%0d.mem_wdata", cyc), mem_wdata, e_wdata);
            end
            if (m_resp_pending) begin
                chk32($sformatf("r%0d.rdata", cyc), m_owner ? lsu_rdata : ifu_rdata, m_data);
            end

            ifu_took = ifu_req_valid && ifu_req_ready;
            lsu_took = lsu_req_valid && lsu_req_ready;

            // Bench memory reacts to what the DUT actually drives.
            if (mem_resp_valid && mem_resp_ready) mem_has = 1'b0;
            if (mem_req_valid && mem_req_ready && !mem_has) begin
                if (mem_wen) begin
                    for (int b = 0; b < MW; b++)
                        if (mem_wmask[b]) mem_arr[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_hold = $urandom;
                end else begin
                    mem_hold = mem_arr[mem_addr[7:2]];
                end
                mem_has   = 1'b1;
                mem_delay = int'($urandom_range(0, 3));
            end

            // Reference model: accept, issue, respond, deliver.
            if (e_lsu_rdy) begin
                m_busy = 1'b1; m_req_pending = 1'b1; m_owner = 1'b1; m_last = 1'b1;
                e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
            end else if (e_ifu_rdy) begin
                m_busy = 1'b1; m_req_pending = 1'b1; m_owner = 1'b0; m_last = 1'b0;
                e_addr = ifu_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
            end else if (m_req_pending && mem_req_ready) begin
                m_req_pending = 1'b0;
                m_wait        = 1'b1;
                if (e_wen) begin
                    for (int b = 0; b < MW; b++)
                        if (e_wmask[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
                end else begin
                    e_rd = ref_mem[e_addr[7:2]];
                end
            end else if (m_wait && mem_resp_valid) begin
                m_wait         = 1'b0;
                m_resp_pending = 1'b1;
                m_data         = e_wen ? mem_rdata : e_rd;
            end else if (m_resp_pending && (m_owner ? lsu_resp_ready : ifu_resp_ready)) begin
                m_resp_pending = 1'b0;
                m_busy         = 1'b0;
                ntx++;
                $display("rand txn %0d: owner=%s addr=%h wen=%b data=%h",
                         ntx, m_owner ? "LSU" : "IFU", e_addr, e_wen, m_data);
            end
            tick();
        end
        chk1("rand.enough_transactions", ntx > 50, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
# ysyx_23060208_mem_arbiter

Two-requester arbiter sharing the single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Each requester and the memory use valid/ready request and response channels. One transaction is in flight at a time. Simultaneous requests are resolved round-robin so neither side starves. The block sits between IFU/LSU and the memory model/SRAM wrapper.

## Interface
- DATA_WIDTH, 32, address/data width; the byte-mask width is DATA_WIDTH/8.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  DATA_WIDTH  fetch address.
- ifu_resp_valid  out  1  fetch data valid.
- ifu_rdata  out  DATA_WIDTH  fetched instruction.
- ifu_resp_ready  in  1  IFU consumes response.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  DATA_WIDTH  data address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_WIDTH  write data.
- lsu_wmask  in  DATA_WIDTH/8  byte write enables.
- lsu_resp_valid  out  1  read data / write ack valid.
- lsu_rdata  out  DATA_WIDTH  read data.
- lsu_resp_ready  in  1  LSU consumes response.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  DATA_WIDTH  address.
- mem_wen  out  1  write enable.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wmask  out  DATA_WIDTH/8  byte mask.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_resp_ready  out  1  arbiter accepts response.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - Grant selection (combinational):
    - Only one requester valid: grant it.
    - Both valid: grant the one not granted last; the `last` register resets to IFU, so the first tie goes to LSU.
  - `<grantee>_req_ready` = 1 only in IDLE and only to the grantee.
  - On handshake:
    - latch addr, wen, wdata and wmask into the request registers; an IFU grant latches wen=0 and wmask=0;
    - record the grantee in `owner` and `last`;
    - go to REQ.
  - No valid request: stay in IDLE.
- **REQ**
  - mem_req_valid=1, driven from the request registers.
  - mem_req_ready=1: go to WAIT. Otherwise hold; fields stay stable.
- **WAIT**
  - mem_resp_ready=1.
  - mem_resp_valid=1: latch mem_rdata into the data register and go to RESP.
- **RESP**
  - `owner`_resp_valid=1 and `owner`_rdata = data register. The other side's resp_valid stays 0.
  - Owner's resp_ready=1: go to IDLE.
- Writes return a response (write ack). lsu_rdata is don't-care for writes but still holds the latched mem_rdata.
- The ifu_rdata/lsu_rdata ports both carry the data register; only resp_valid is qualified by owner.
- Requests arriving while not IDLE are ignored: ready=0, and the requester must hold valid.

## Timing
- Reset values:
  - all valid/ready outputs 0;
  - request and data registers 0;
  - state IDLE; `last` = IFU; `owner` = IFU.
- Reset mid-transaction: return to IDLE next cycle and drop the in-flight transaction; no response is issued.
- Minimum latency with memory ready and zero-latency responses:
  - request handshake at cycle T (IDLE);
  - mem_req_valid at T+1;
  - mem_resp_valid sampled at T+2;
  - resp_valid at T+3;
  - IDLE at T+4.
  - Throughput: one transaction per 4 cycles minimum.
- req_ready depends combinationally on the req_valid inputs. Requesters must not make valid depend on ready.
- mem_req_valid, mem_resp_ready and all resp_valid outputs are pure functions of the registered state (no combinational input paths).
- A new request arriving in the same cycle as the RESP handshake is not accepted until the following IDLE cycle.

## Test plan
- **IFU alone.** ifu_addr=0x80000000, memory returns 0x00000413 with 0 wait.
  - ifu_req_ready at T, mem_req_valid at T+1, ifu_resp_valid=1 with ifu_rdata=0x00000413 at T+3.
  - lsu_resp_valid stays 0 throughout.
- **Simultaneous requests after reset.** IFU and LSU both valid at T.
  - LSU is granted first.
  - After its response completes, IFU is granted at the next IDLE.
  - With both held valid continuously, grants alternate LSU, IFU, LSU…
- **LSU write.** addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011.
  - mem_wen=1, mem_wdata=0xDEADBEEF and mem_wmask=0011 are held stable while mem_req_ready=0 for 3 cycles.
  - lsu_resp_valid is asserted once after the mem response.
- **Backpressure.**
  - mem_resp_valid delayed 5 cycles: arbiter holds WAIT with mem_resp_ready=1.
  - ifu_resp_ready low for 4 cycles: ifu_resp_valid and ifu_rdata stay stable; IFU request ready remains 0.
- **Reset mid-transaction.** rst asserted in WAIT.
  - Next cycle: all outputs 0, state IDLE.
  - Next tie grants LSU again.
